// File: rtl/uc_periph_pkg.sv
// Shared definitions for the 68HC05 peripheral slice: register map, register
// layouts, SPI sequencer states and the SPR-to-SCK-rate helper.
package uc_periph_pkg;

  localparam logic [1:0] ADDR_SPCR = 2'd0;
  localparam logic [1:0] ADDR_SPSR = 2'd1;
  localparam logic [1:0] ADDR_SPDR = 2'd2;

  // Wide enough for E_DIV up to 2047 at the slowest SPR setting.
  localparam int HALF_W = 16;

  typedef struct packed {
    logic       spie;
    logic       spe;
    logic       rsvd;
    logic       mstr;
    logic       cpol;
    logic       cpha;
    logic [1:0] spr;
  } spcr_t;

  typedef struct packed {
    logic       spif;
    logic       wcol;
    logic       rsvd5;
    logic       modf;
    logic [3:0] rsvd;
  } spsr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } spi_state_e;

  function automatic int unsigned spr_ratio(input logic [1:0] spr);
    case (spr)
      2'b00:   return 2;
      2'b01:   return 4;
      2'b10:   return 16;
      default: return 32;
    endcase
  endfunction

  // SCK half-period in clk cycles, never below one.
  function automatic logic [HALF_W-1:0] half_period(input int unsigned e_div,
                                                    input logic [1:0]  spr);
    int unsigned h;
    h = (e_div * spr_ratio(spr)) / 2;
    if (h == 0) h = 1;
    return HALF_W'(h);
  endfunction

endpackage

// File: rtl/uc_clk_div.sv
// Loadable half-period counter: tick pulses on the last clk cycle of every
// 'half' cycles while enabled; clr restarts the period from zero.
module uc_clk_div #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] half,
  output logic         tick
);

  logic [W-1:0] cnt_q;

  assign tick = en && (cnt_q == (half - W'(1)));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/uc_spi_master.sv
// 68HC05-style SPI master: SPCR/SPSR/SPDR register file, CPOL/CPHA edge
// sequencing of an 8-bit shifter, SPIF/WCOL/MODF handshakes and interrupt.
module uc_spi_master #(
  parameter int E_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bus_sel,
  input  logic       bus_we,
  input  logic [1:0] bus_addr,
  input  logic [7:0] bus_wdata,
  output logic [7:0] bus_rdata,
  output logic       irq,
  output logic       sck,
  output logic       mosi,
  input  logic       miso,
  input  logic       ss_n,
  output logic       spi_oe
);

  import uc_periph_pkg::*;

  spi_state_e        state_q, state_d;
  spcr_t             spcr_q;
  spsr_t             spsr_rd;
  logic              spif_q, wcol_q, modf_q;
  logic              arm_spif_q, arm_wcol_q, arm_modf_q;
  logic              ss_low_q;
  logic [7:0]        sh_q, rx_buf_q;
  logic              smp_q, mosi_q, sck_q;
  logic              cpol_q, cpha_q;
  logic [HALF_W-1:0] half_q;
  logic [3:0]        edge_q;

  logic wr_spcr, rd_spsr, acc_spdr, wr_spdr;
  logic modf_det, stop, tick, last_edge;
  logic start, div_en, sck_tick, complete, busy;

  assign wr_spcr  = bus_sel && bus_we && (bus_addr == ADDR_SPCR);
  assign rd_spsr  = bus_sel && !bus_we && (bus_addr == ADDR_SPSR);
  assign acc_spdr = bus_sel && (bus_addr == ADDR_SPDR);
  assign wr_spdr  = acc_spdr && bus_we;

  // ss_n must be low on two consecutive samples before it counts as a fault.
  assign modf_det  = spcr_q.mstr && !ss_n && ss_low_q;
  assign stop      = modf_det || (wr_spcr && !(bus_wdata[6] && bus_wdata[4]));
  assign last_edge = (edge_q == 4'd15);

  uc_clk_div #(.W(HALF_W)) u_clk_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (start),
    .en   (div_en),
    .half (half_q),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_spdr && spcr_q.spe && spcr_q.mstr && !modf_q && !modf_det)
          state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (stop)                   state_d = ST_IDLE;
        else if (tick && last_edge) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    start    = 1'b0;
    div_en   = 1'b0;
    sck_tick = 1'b0;
    complete = 1'b0;
    busy     = 1'b1;
    case (state_q)
      ST_IDLE: begin
        busy  = 1'b0;
        start = (state_d == ST_SHIFT);
      end
      ST_SHIFT: begin
        div_en   = 1'b1;
        sck_tick = tick && !stop;
      end
      ST_DONE:  complete = !stop;
      default:  busy = 1'b0;
    endcase
  end

  // Shift datapath. Timing mode and rate are frozen at start so SPCR writes
  // mid-transfer only affect the next byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_q     <= '0;
      rx_buf_q <= '0;
      smp_q    <= 1'b0;
      mosi_q   <= 1'b0;
      sck_q    <= 1'b0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      half_q   <= HALF_W'(1);
      edge_q   <= '0;
    end else begin
      if (start) begin
        sh_q   <= bus_wdata;
        half_q <= half_period(E_DIV, spcr_q.spr);
        cpol_q <= spcr_q.cpol;
        cpha_q <= spcr_q.cpha;
        sck_q  <= spcr_q.cpol;
        edge_q <= '0;
        if (!spcr_q.cpha) mosi_q <= bus_wdata[7];
      end else if (wr_spdr && !busy) begin
        sh_q <= bus_wdata;
      end else if (sck_tick) begin
        sck_q  <= ~sck_q;
        edge_q <= edge_q + 4'd1;
        if (!edge_q[0]) begin
          // Odd (1st, 3rd, ...) SCK edge.
          if (cpha_q) mosi_q <= sh_q[7];
          else        smp_q  <= miso;
        end else if (cpha_q) begin
          sh_q <= {sh_q[6:0], miso};
        end else begin
          sh_q   <= {sh_q[6:0], smp_q};
          mosi_q <= sh_q[6];
        end
      end
      if (complete) rx_buf_q <= sh_q;
    end
  end

  // Control/status registers. Flag sets are ordered after clears so a
  // same-cycle set wins; MODF's forced SPE/MSTR drop overrides an SPCR write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spcr_q     <= '0;
      spif_q     <= 1'b0;
      wcol_q     <= 1'b0;
      modf_q     <= 1'b0;
      arm_spif_q <= 1'b0;
      arm_wcol_q <= 1'b0;
      arm_modf_q <= 1'b0;
      ss_low_q   <= 1'b0;
    end else begin
      ss_low_q <= !ss_n;

      if (wr_spcr) begin
        spcr_q      <= spcr_t'(bus_wdata);
        spcr_q.rsvd <= 1'b0;
      end
      if (modf_det) begin
        spcr_q.spe  <= 1'b0;
        spcr_q.mstr <= 1'b0;
      end

      if (acc_spdr && arm_spif_q) spif_q <= 1'b0;
      if (complete)               spif_q <= 1'b1;

      if (acc_spdr && arm_wcol_q) wcol_q <= 1'b0;
      if (wr_spdr && busy)        wcol_q <= 1'b1;

      if (wr_spcr && arm_modf_q)  modf_q <= 1'b0;
      if (modf_det)               modf_q <= 1'b1;

      // Only an SPSR read arms a clear; any other access drops the arm.
      if (bus_sel) begin
        arm_spif_q <= rd_spsr && spif_q;
        arm_wcol_q <= rd_spsr && wcol_q;
        arm_modf_q <= rd_spsr && modf_q;
      end
    end
  end

  always_comb begin
    spsr_rd      = '0;
    spsr_rd.spif = spif_q;
    spsr_rd.wcol = wcol_q;
    spsr_rd.modf = modf_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_rdata <= '0;
    end else if (bus_sel && !bus_we) begin
      case (bus_addr)
        ADDR_SPCR: bus_rdata <= spcr_q;
        ADDR_SPSR: bus_rdata <= spsr_rd;
        ADDR_SPDR: bus_rdata <= rx_buf_q;
        default:   bus_rdata <= '0;
      endcase
    end
  end

  // Outside a transfer SCK follows CPOL directly, so an abort parks it at once.
  assign sck    = (state_q == ST_SHIFT) ? sck_q : spcr_q.cpol;
  assign mosi   = mosi_q;
  assign irq    = spcr_q.spie && (spif_q || modf_q);
  assign spi_oe = spcr_q.spe && spcr_q.mstr;

endmodule
